// File: rtl/serial_shift_out.sv
// serial_shift_out: shifts WIDTH-bit words out on an o_sdat/o_sclk pin pair at a
// programmable bit rate. A one-word holding buffer lets consecutive words run
// back to back without a gap.
// Optional feature macro: SERIAL_SHIFT_OUT_LATCH_EN adds a LATCH state that
// pulses o_latch for CLK_DIV cycles after each burst. Without it, o_latch is 0.
module serial_shift_out #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_sdat,
    output logic             o_sclk,
    output logic             o_latch,
    output logic             o_busy
);

    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

`ifdef SERIAL_SHIFT_OUT_LATCH_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_buf;
    logic             r_full;
    logic [HW-1:0]    r_half_cnt;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_sdat;
    logic             r_sclk;

    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_buf_nxt;
    logic             w_full_nxt;
    logic [HW-1:0]    w_half_nxt;
    logic [BW-1:0]    w_bit_nxt;
    logic             w_sdat_nxt;
    logic             w_sclk_nxt;
    logic [WIDTH-1:0] w_advanced;
    logic [WIDTH-1:0] w_chain_word;

    logic             w_accept;
    logic             w_half_last;
    logic             w_bit_last;
    logic             w_word_end;
    logic             w_chain;

`ifdef SERIAL_SHIFT_OUT_LATCH_EN
    logic             r_latch;
    logic             w_latch_nxt;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    assign w_accept     = i_valid & ~r_full;
    assign w_half_last  = (r_half_cnt == HALF_LAST);
    assign w_bit_last   = (r_bit_cnt == BIT_LAST);
    assign w_word_end   = (r_state == ST_SHIFT) & r_sclk & w_half_last & w_bit_last;
    // A word offered in the final cycle of a word is chained as if it were buffered.
    assign w_chain      = r_full | w_accept;
    assign w_advanced   = advance(r_shift);
    assign w_chain_word = r_full ? r_buf : i_data;

    assign o_ready = ~r_full;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_sdat  = r_sdat;
    assign o_sclk  = r_sclk;
`ifdef SERIAL_SHIFT_OUT_LATCH_EN
    assign o_latch = r_latch;
`else
    assign o_latch = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_word_end && !w_chain) begin
`ifdef SERIAL_SHIFT_OUT_LATCH_EN
                    w_state_nxt = ST_LATCH;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef SERIAL_SHIFT_OUT_LATCH_EN
            ST_LATCH: begin
                if (w_half_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the datapath and the registered pin outputs.
    always_comb begin
        w_shift_nxt = r_shift;
        w_buf_nxt   = r_buf;
        w_full_nxt  = r_full;
        w_half_nxt  = r_half_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_sdat_nxt  = r_sdat;
        w_sclk_nxt  = r_sclk;
`ifdef SERIAL_SHIFT_OUT_LATCH_EN
        w_latch_nxt = r_latch;
`endif
        case (r_state)
            ST_IDLE: begin
                w_sdat_nxt = 1'b0;
                w_sclk_nxt = 1'b0;
                w_half_nxt = '0;
                w_bit_nxt  = '0;
                if (w_accept) begin
                    w_shift_nxt = i_data;
                    w_sdat_nxt  = first_bit(i_data);
                end
            end
            ST_SHIFT: begin
                if (w_accept && !w_word_end) begin
                    w_buf_nxt  = i_data;
                    w_full_nxt = 1'b1;
                end
                if (!w_half_last) begin
                    w_half_nxt = r_half_cnt + HW'(1);
                end else begin
                    w_half_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else if (!w_bit_last) begin
                        w_sclk_nxt  = 1'b0;
                        w_shift_nxt = w_advanced;
                        w_sdat_nxt  = first_bit(w_advanced);
                        w_bit_nxt   = r_bit_cnt + BW'(1);
                    end else if (w_chain) begin
                        w_sclk_nxt  = 1'b0;
                        w_shift_nxt = w_chain_word;
                        w_sdat_nxt  = first_bit(w_chain_word);
                        w_bit_nxt   = '0;
                        w_full_nxt  = 1'b0;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        w_sdat_nxt = 1'b0;
                        w_bit_nxt  = '0;
`ifdef SERIAL_SHIFT_OUT_LATCH_EN
                        w_latch_nxt = 1'b1;
`endif
                    end
                end
            end
`ifdef SERIAL_SHIFT_OUT_LATCH_EN
            ST_LATCH: begin
                if (w_half_last) begin
                    w_half_nxt  = '0;
                    w_latch_nxt = 1'b0;
                end else begin
                    w_half_nxt = r_half_cnt + HW'(1);
                end
            end
`endif
            default: begin
                w_sdat_nxt = 1'b0;
                w_sclk_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and pin registers; reset discards in-flight and buffered words.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_buf      <= '0;
            r_full     <= 1'b0;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_sdat     <= 1'b0;
            r_sclk     <= 1'b0;
`ifdef SERIAL_SHIFT_OUT_LATCH_EN
            r_latch    <= 1'b0;
`endif
        end else begin
            r_shift    <= w_shift_nxt;
            r_buf      <= w_buf_nxt;
            r_full     <= w_full_nxt;
            r_half_cnt <= w_half_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_sdat     <= w_sdat_nxt;
            r_sclk     <= w_sclk_nxt;
`ifdef SERIAL_SHIFT_OUT_LATCH_EN
            r_latch    <= w_latch_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_shift_out.sv
// Directed bench for serial_shift_out, WIDTH=8, CLK_DIV=2. Cycle t is the cycle
// whose closing rising edge accepts a word; outputs are sampled on falling edges.
module tb_serial_shift_out;

`ifdef SERIAL_SHIFT_OUT_LATCH_EN
    localparam bit LATCH_ON = 1'b1;
`else
    localparam bit LATCH_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = '0;
    logic       ready, sdat, sclk, latch, busy;
    logic       valid2 = 1'b0;
    logic [7:0] data2 = '0;
    logic       ready2, sdat2, sclk2, latch2, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_shift_out #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
        .o_ready(ready), .o_sdat(sdat), .o_sclk(sclk), .o_latch(latch), .o_busy(busy)
    );

    serial_shift_out #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .i_data(data2),
        .o_ready(ready2), .o_sdat(sdat2), .o_sclk(sclk2), .o_latch(latch2), .o_busy(busy2)
    );

    // Expected {busy,sdat,sclk,latch} for cycle t+k of a burst of nwords words:
    // each bit is 2 low cycles then 2 high cycles, 32 cycles per word.
    function automatic logic [3:0] model(input int k, input logic [7:0] w0,
                                         input logic [7:0] w1, input int nwords,
                                         input bit msb);
        int         i;
        int         b;
        logic [7:0] w;
        if (k >= 1 && k <= 32 * nwords) begin
            i = (k - 1) % 32;
            w = ((k - 1) / 32 == 0) ? w0 : w1;
            b = i / 4;
            return {1'b1, (msb ? w[7 - b] : w[b]), ((i % 4) >= 2), 1'b0};
        end
        if (LATCH_ON && k <= 32 * nwords + 2) return 4'b1001;
        return 4'b0000;
    endfunction

    task automatic test_reset();
        logic [4:0] obs;
        rst_n = 1'b0; valid = 1'b0; data = '0;
        repeat (2) @(negedge clk);
        obs = {busy, sdat, sclk, latch, ready};
        checks++;
        if (obs !== 5'b00001) begin
            errors++; $display("FAIL reset_initial got %b exp %b", obs, 5'b00001);
        end
        rst_n = 1'b1;
        @(negedge clk);
        valid = 1'b1; data = 8'hFF;
        @(posedge clk);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 1) data = 8'h5A;
            if (k == 2) valid = 1'b0;
        end
        obs = {busy, sdat, sclk, latch, ready};
        checks++;
        if (obs !== 5'b11100) begin
            errors++; $display("FAIL reset_preword got %b exp %b", obs, 5'b11100);
        end
        #2 rst_n = 1'b0;
        #1;
        obs = {busy, sdat, sclk, latch, ready};
        checks++;
        if (obs !== 5'b00001) begin
            errors++; $display("FAIL reset_async got %b exp %b", obs, 5'b00001);
        end
        valid = 1'b1; data = 8'hC3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {busy, sdat, sclk, latch, ready};
        checks++;
        if (obs !== 5'b00001) begin
            errors++; $display("FAIL reset_valid_ignored got %b exp %b", obs, 5'b00001);
        end
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        obs = {busy, sdat, sclk, latch, ready};
        checks++;
        if (obs !== 5'b00001) begin
            errors++; $display("FAIL reset_release got %b exp %b", obs, 5'b00001);
        end
    endtask

    task automatic test_single();
        logic [4:0] obs;
        logic [4:0] exp;
        valid = 1'b1; data = 8'hA5;
        @(posedge clk);
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            obs = {busy, sdat, sclk, latch, ready};
            exp = {model(k, 8'hA5, 8'h00, 1, 1'b1), 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL single t+%0d got %b exp %b", k, obs, exp);
            end
            if (k == 1) valid = 1'b0;
        end
    endtask

    task automatic test_lsb_first();
        logic [4:0] obs;
        logic [4:0] exp;
        valid2 = 1'b1; data2 = 8'h01;
        @(posedge clk);
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            obs = {busy2, sdat2, sclk2, latch2, ready2};
            exp = {model(k, 8'h01, 8'h00, 1, 1'b0), 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL lsb_first t+%0d got %b exp %b", k, obs, exp);
            end
            if (k == 1) valid2 = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] obs;
        logic [4:0] exp;
        valid = 1'b1; data = 8'h81;
        @(posedge clk);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            obs = {busy, sdat, sclk, latch, ready};
            exp = {model(k, 8'h81, 8'h7E, 2, 1'b1), !(k >= 6 && k <= 32)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL back_to_back t+%0d got %b exp %b", k, obs, exp);
            end
            if (k == 1) valid = 1'b0;
            if (k == 5) begin valid = 1'b1; data = 8'h7E; end
            if (k == 6) valid = 1'b0;
        end
    endtask

    task automatic test_boundary();
        logic [4:0] obs;
        logic [4:0] exp;
        valid = 1'b1; data = 8'h3C;
        @(posedge clk);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            obs = {busy, sdat, sclk, latch, ready};
            exp = {model(k, 8'h3C, 8'hC3, 2, 1'b1), 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL boundary t+%0d got %b exp %b", k, obs, exp);
            end
            if (k == 1) valid = 1'b0;
            if (k == 32) begin valid = 1'b1; data = 8'hC3; end
            if (k == 33) valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_lsb_first();
        test_back_to_back();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_shift_out.md
# serial_shift_out

Parametrised serial output engine that shifts WIDTH-bit words out on a data/clock pin pair, with a programmable bit rate, selectable bit order and a one-word holding buffer for gap-free back-to-back words. It sits between the core logic and the I/O pins that drive external shift-register chains (LED/segment drivers, 74HC595-style expanders). It supersedes the fixed 8-bit, fixed-rate shifter, which had no buffering and no latch strobe.

## Interface
- WIDTH, 8: bits per word; legal range ≥ 2.
- CLK_DIV, 1: i_clk cycles per half-period of o_sclk; legal range ≥ 1.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  word offered on i_data.
- i_data  input  WIDTH  word to shift.
- o_ready  output  1  holding buffer empty; a word is accepted when i_valid & o_ready.
- o_sdat  output  1  serial data; registered.
- o_sclk  output  1  serial clock; registered; data sampled externally on rising edge.
- o_latch  output  1  storage-register strobe (see Configuration); registered.
- o_busy  output  1  engine not IDLE.

## Operation
- States: IDLE, SHIFT, LATCH (LATCH exists only with the macro).
- Holding buffer: one WIDTH-bit register plus full flag. o_ready = ~full.
- IDLE: buffer is always empty. An accepted word loads straight into the shift register; state → SHIFT.
- SHIFT, per bit: CLK_DIV cycles with o_sclk=0 and o_sdat = current bit, then CLK_DIV cycles with o_sclk=1, o_sdat unchanged. o_sdat changes only in the cycle o_sclk falls (or first low cycle).
- Word length: exactly 2·CLK_DIV·WIDTH cycles.
- Acceptance during SHIFT fills the buffer; o_ready drops the next cycle.
- End of word (last cycle of last high phase):
  - buffer full → shift register loads buffer, buffer cleared, next word's first low phase starts next cycle (no gap, no latch).
  - buffer empty → LATCH (macro on) or IDLE (macro off).
- A word accepted in the final cycle of a word counts as buffer-full at that edge: it is chained without a gap.
- Counters: half-period counter width $clog2(CLK_DIV)+1; bit counter width $clog2(WIDTH)+1; no wrap beyond terminal values.
- Idle levels: o_sdat=0, o_sclk=0, o_latch=0.
- Reset (any time, including mid-word): immediately o_sdat=0, o_sclk=0, o_latch=0, o_busy=0, buffer empty (o_ready=1), state IDLE, counters 0. In-flight and buffered words are discarded; i_valid is ignored while i_rst_n=0.

## Timing
- Accept at edge t from IDLE: o_busy=1 and first bit on o_sdat from cycle t+1; first o_sclk rise at cycle t+1+CLK_DIV.
- Last o_sclk high phase ends at cycle t+2·CLK_DIV·WIDTH.
- Macro on: o_latch=1 for cycles t+2·CLK_DIV·WIDTH+1 … +CLK_DIV, o_sclk=0, o_sdat=0; then IDLE.
- o_busy falls the cycle the state returns to IDLE; o_ready is 1 whenever the buffer is empty, including IDLE.
- Throughput: one word per 2·CLK_DIV·WIDTH cycles while the buffer is kept full.

## Configuration
- SERIAL_SHIFT_OUT_LATCH_EN defined: LATCH state present; one o_latch pulse of CLK_DIV cycles after each burst (word whose end finds the buffer empty).
- Undefined: no LATCH state; end of burst goes straight to IDLE; o_latch tied to 0; word timing otherwise identical.

## Test plan
- Reset: drive i_rst_n=0 mid-word (WIDTH=8, CLK_DIV=2, word 0xFF, after bit 3) -> o_sdat/o_sclk/o_latch/o_busy = 0 asynchronously, o_ready=1; next word after release shifts cleanly from its first bit.
- Single word, WIDTH=8, CLK_DIV=2, MSB_FIRST=1, 0xA5 accepted at t -> o_sdat 1,0,1,0,0,1,0,1, each held 4 cycles from t+1; o_sclk rises at t+3,t+7,…,t+31; macro on: o_latch=1 at t+33..t+34, o_busy=0 at t+35.
- Bit order: MSB_FIRST=0, 0x01 -> first bit 1, remaining seven 0.
- Back-to-back: 0x81 at t, 0x7E offered at t+5 -> o_ready=0 from t+6 until t+33; 64 contiguous sclk-toggling cycles, exactly one o_latch pulse after the second word.
- Boundary: second word accepted in cycle t+32 (final cycle) -> chained with no gap, no latch between words.
- Macro off: same 0xA5 stimulus -> identical o_sdat/o_sclk, o_latch constant 0, o_busy=0 at t+33.
